object_plotter: RTL



---
 rtl/gfx_pkg.sv | 37 +++
 rtl/rect_scanner.sv | 75 +++++++
 rtl/object_plotter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/gfx_pkg.sv
// Shared types and limits for the game-logic to VGA plotter path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package gfx_pkg;

    // Coordinate and colour widths of the VGA adapter write port.
    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int COL_W = 3;

    // Largest on-screen coordinates of the 160x120 adapter.
    localparam int SCR_MAX_X = 159;
    localparam int SCR_MAX_Y = 119;

    // Default palette.
    localparam logic [COL_W-1:0] DEF_BG_COLOUR     = 3'b000;
    localparam logic [COL_W-1:0] DEF_BALL_COLOUR   = 3'b111;
    localparam logic [COL_W-1:0] DEF_PADDLE_COLOUR = 3'b011;
    localparam logic [COL_W-1:0] DEF_BLOCK_COLOUR  = 3'b100;

    // Object codes announced by the game logic.
    typedef enum logic [1:0] {
        OBJ_BALL   = 2'b00,
        OBJ_PADDLE = 2'b01,
        OBJ_BLOCK  = 2'b10,
        OBJ_NONE   = 2'b11
    } obj_t;

    // Plotter sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ERASE  = 2'b01,
        DRAW   = 2'b10,
        FINISH = 2'b11
    } plot_state_t;

endpackage

// File: rtl/rect_scanner.sv
// Raster scanner over a WxH rectangle: x is the fast index, y the slow one.
// Latency: nextX/nextY show the address the counters take at the coming edge (zero-cycle lookahead).
// Backpressure: none; advances only when step is asserted, load restarts at (0,0).
// Ports: clk/reset; load with ldBase*/ldSize* (size 0 counts as 1); step;
//        nextX/nextY = base + counters after this edge (9/8 bits); last = current counter is final pixel.
module rect_scanner
    import gfx_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           step,
    input  logic [X_W-1:0] ldBaseX,
    input  logic [Y_W-1:0] ldBaseY,
    input  logic [X_W-1:0] ldSizeX,
    input  logic [Y_W-1:0] ldSizeY,
    output logic [X_W:0]   nextX,
    output logic [Y_W:0]   nextY,
    output logic           last
);

    logic [X_W-1:0] baseX, wMax, cx;
    logic [Y_W-1:0] baseY, hMax, cy;
    logic [X_W-1:0] nBaseX, nWMax, nCx;
    logic [Y_W-1:0] nBaseY, nHMax, nCy;

    always_comb begin
        nBaseX = baseX;
        nBaseY = baseY;
        nWMax  = wMax;
        nHMax  = hMax;
        nCx    = cx;
        nCy    = cy;
        if (load) begin
            nBaseX = ldBaseX;
            nBaseY = ldBaseY;
            // Stored as extent-1 so a zero size collapses to a single pixel.
            nWMax  = (ldSizeX == '0) ? '0 : ldSizeX - 1'b1;
            nHMax  = (ldSizeY == '0) ? '0 : ldSizeY - 1'b1;
            nCx    = '0;
            nCy    = '0;
        end else if (step) begin
            if (cx == wMax) begin
                nCx = '0;
                nCy = (cy == hMax) ? '0 : cy + 1'b1;
            end else begin
                nCx = cx + 1'b1;
            end
        end
    end

    // One extra bit so off-screen sums are seen rather than wrapping back on screen.
    assign nextX = {1'b0, nBaseX} + {1'b0, nCx};
    assign nextY = {1'b0, nBaseY} + {1'b0, nCy};
    assign last  = (cx == wMax) && (cy == hMax);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baseX <= '0;
            baseY <= '0;
            wMax  <= '0;
            hMax  <= '0;
            cx    <= '0;
            cy    <= '0;
        end else begin
            baseX <= nBaseX;
            baseY <= nBaseY;
            wMax  <= nWMax;
            hMax  <= nHMax;
            cx    <= nCx;
            cy    <= nCy;
        end
    end

endmodule

// File: rtl/object_plotter.sv
// Erases an object's old rectangle, then draws its new one, through the VGA adapter pixel port.
// Latency: first pixel the cycle after start_plot; busy for 2*W*H+1 cycles ending with a done pulse.
// Backpressure: none; start_plot while busy is dropped and latches the sticky overrun flag.
// Ports: clk, reset (async, high); start_plot with object/new_*/old_*/size_* valid that cycle;
//        vga_x/vga_y/vga_colour/vga_plot registered pixel write; busy, done, overrun status.
module object_plotter
    import gfx_pkg::*;
#(
    parameter int               MAX_X         = SCR_MAX_X,
    parameter int               MAX_Y         = SCR_MAX_Y,
    parameter logic [COL_W-1:0] BG_COLOUR     = DEF_BG_COLOUR,
    parameter logic [COL_W-1:0] BALL_COLOUR   = DEF_BALL_COLOUR,
    parameter logic [COL_W-1:0] PADDLE_COLOUR = DEF_PADDLE_COLOUR,
    parameter logic [COL_W-1:0] BLOCK_COLOUR  = DEF_BLOCK_COLOUR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_plot,
    input  logic [1:0]       object,
    input  logic [X_W-1:0]   new_x,
    input  logic [Y_W-1:0]   new_y,
    input  logic [X_W-1:0]   old_x,
    input  logic [Y_W-1:0]   old_y,
    input  logic [X_W-1:0]   size_x,
    input  logic [Y_W-1:0]   size_y,
    output logic [X_W-1:0]   vga_x,
    output logic [Y_W-1:0]   vga_y,
    output logic [COL_W-1:0] vga_colour,
    output logic             vga_plot,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    localparam logic [X_W:0] X_LIMIT = (X_W+1)'(MAX_X);
    localparam logic [Y_W:0] Y_LIMIT = (Y_W+1)'(MAX_Y);

    plot_state_t state, nextState;

    logic [X_W-1:0]   newXq, sizeXq;
    logic [Y_W-1:0]   newYq, sizeYq;
    obj_t             objQ;

    logic             accept, emit, scLoad, scStep, scLast, onScreen;
    logic [X_W-1:0]   ldBaseX, ldSizeX;
    logic [Y_W-1:0]   ldBaseY, ldSizeY;
    logic [X_W:0]     pixX;
    logic [Y_W:0]     pixY;
    logic [COL_W-1:0] drawColour, pixColour;

    rect_scanner scanner (
        .clk     (clk),
        .reset   (reset),
        .load    (scLoad),
        .step    (scStep),
        .ldBaseX (ldBaseX),
        .ldBaseY (ldBaseY),
        .ldSizeX (ldSizeX),
        .ldSizeY (ldSizeY),
        .nextX   (pixX),
        .nextY   (pixY),
        .last    (scLast)
    );

    always_comb begin
        case (objQ)
            OBJ_BALL:   drawColour = BALL_COLOUR;
            OBJ_PADDLE: drawColour = PADDLE_COLOUR;
            OBJ_BLOCK:  drawColour = BLOCK_COLOUR;
            default:    drawColour = BG_COLOUR;
        endcase
    end

    // The output registers load the pixel the scanner moves to at this edge,
    // so what is on vga_* always matches the state being entered.
    always_comb begin
        nextState = state;
        accept    = 1'b0;
        emit      = 1'b0;
        scLoad    = 1'b0;
        scStep    = 1'b0;
        ldBaseX   = newXq;
        ldBaseY   = newYq;
        ldSizeX   = sizeXq;
        ldSizeY   = sizeYq;
        pixColour = BG_COLOUR;
        case (state)
            IDLE: begin
                if (start_plot && (object != OBJ_NONE)) begin
                    accept    = 1'b1;
                    scLoad    = 1'b1;
                    emit      = 1'b1;
                    ldBaseX   = old_x;
                    ldBaseY   = old_y;
                    ldSizeX   = size_x;
                    ldSizeY   = size_y;
                    nextState = ERASE;
                end
            end
            ERASE: begin
                emit = 1'b1;
                if (scLast) begin
                    // Rebase onto the new rectangle; sizes come from the latched copy.
                    scLoad    = 1'b1;
                    pixColour = drawColour;
                    nextState = DRAW;
                end else begin
                    scStep = 1'b1;
                end
            end
            DRAW: begin
                if (scLast) begin
                    nextState = FINISH;
                end else begin
                    scStep    = 1'b1;
                    emit      = 1'b1;
                    pixColour = drawColour;
                end
            end
            FINISH: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign onScreen = (pixX <= X_LIMIT) && (pixY <= Y_LIMIT);
    assign busy     = (state != IDLE);
    assign done     = (state == FINISH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            newXq      <= '0;
            newYq      <= '0;
            sizeXq     <= '0;
            sizeYq     <= '0;
            objQ       <= OBJ_BALL;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (accept) begin
                newXq  <= new_x;
                newYq  <= new_y;
                sizeXq <= size_x;
                sizeYq <= size_y;
                objQ   <= obj_t'(object);
            end
            // Off-screen pixels still advance the scan and show their truncated address.
            vga_plot <= emit && onScreen;
            if (emit) begin
                vga_x      <= pixX[X_W-1:0];
                vga_y      <= pixY[Y_W-1:0];
                vga_colour <= pixColour;
            end
            if (start_plot && (state != IDLE)) overrun <= 1'b1;
        end
    end

endmodule
